// File: rtl/demux_1_4_stream_if.sv
// Stream bundle for the 1:4 packet demux.
//   in_data/in_sel/in_valid/in_last : shared producer word, destination and framing
//   in_ready                        : producer word accepted when in_valid & in_ready
//   out_data/out_valid/out_last     : four registered consumer channels, channel k at
//                                     out_data[k*WIDTH +: WIDTH]
//   out_ready                       : per-channel consumer ready
// Modports: master = producer/consumer side, slave = demux side.
interface demux_1_4_stream_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_last;
  logic [3:0]         out_ready;

  modport master (
    output in_data, in_sel, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_sel, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// Packet-aware 1:4 stream demux with one register stage per output channel.
// The destination is taken from in_sel on a packet's first word and locked until the
// word flagged last. Each channel keeps a wrapping count of completed packets.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : stream bundle (slave view), see demux_1_4_stream_if
//   busy       : 1 while mid-packet
//   cur_sel    : channel locked for the current packet, 0 when idle
//   pkt_cnt    : channel k completed-packet count at [k*CNT_W +: CNT_W]
module demux_1_4_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  demux_1_4_stream_if.slave    bus,
  output logic                 busy,
  output logic [1:0]           cur_sel,
  output logic [4*CNT_W-1:0]   pkt_cnt
);

  typedef enum logic [0:0] {StIdle, StRoute} state_e;

  state_e             state_q;
  logic [1:0]         cur_sel_q;
  logic [4*WIDTH-1:0] out_data_q;
  logic [3:0]         out_valid_q;
  logic [3:0]         out_last_q;
  logic [4*CNT_W-1:0] pkt_cnt_q;

  logic [1:0] eff_sel;
  logic       in_ready;
  logic       accept;

  // Idle: the word itself names its channel. Mid-packet: the locked channel is used.
  // Ready depends combinationally on the target channel's out_ready.
  always_comb begin
    eff_sel  = (state_q == StIdle) ? bus.in_sel : cur_sel_q;
    in_ready = !out_valid_q[eff_sel] || bus.out_ready[eff_sel];
    accept   = bus.in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_sel_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      out_last_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (eff_sel == 2'(k))) begin
          // A new write wins over a simultaneous drain of the same channel.
          out_data_q[k*WIDTH +: WIDTH] <= bus.in_data;
          out_valid_q[k]               <= 1'b1;
          out_last_q[k]                <= bus.in_last;
          if (bus.in_last) begin
            pkt_cnt_q[k*CNT_W +: CNT_W] <= pkt_cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end else if (out_valid_q[k] && bus.out_ready[k]) begin
          out_valid_q[k] <= 1'b0;
        end
      end

      if (accept) begin
        unique case (state_q)
          StIdle: begin
            if (!bus.in_last) begin
              state_q   <= StRoute;
              cur_sel_q <= bus.in_sel;
            end
          end
          StRoute: begin
            if (bus.in_last) begin
              state_q   <= StIdle;
              cur_sel_q <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q == StRoute);
  assign cur_sel       = cur_sel_q;
  assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_demux_1_4_stream.sv
module tb_demux_1_4_stream;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          busy;
  logic [1:0]    cur_sel;
  logic [4*CW-1:0] pkt_cnt;

  int vectors = 0;
  int errors  = 0;

  // Expected contents per channel as {last, data}, oldest first.
  logic [W:0] exp_q [4][$];

  demux_1_4_stream_if #(.WIDTH(W)) bus ();

  demux_1_4_stream #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .busy   (busy),
    .cur_sel(cur_sel),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ch_data(input int k);
    return bus.out_data[k*W +: W];
  endfunction

  function automatic logic [CW-1:0] ch_cnt(input int k);
    return pkt_cnt[k*CW +: CW];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] d, input logic [1:0] s, input logic l);
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    bus.in_data = '0;
    bus.in_sel  = 2'd0;
    bus.in_last = 1'b0;
    do_reset();
    vectors++;
    if (bus.out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b want 0000", bus.out_valid);
    end
    vectors++;
    if (bus.out_data !== 64'h0 || bus.out_last !== 4'b0000) begin
      errors++; $display("FAIL reset_data: got %h/%b want 0/0", bus.out_data, bus.out_last);
    end
    vectors++;
    if (busy !== 1'b0 || cur_sel !== 2'd0 || pkt_cnt !== '0) begin
      errors++; $display("FAIL reset_state: got busy=%b sel=%0d cnt=%h want 0", busy, cur_sel,
                         pkt_cnt);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single_word;
    bus.out_ready = 4'b0100;
    drive(16'hA5A5, 2'd2, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 4'b0100 || ch_data(2) !== 16'hA5A5 || bus.out_last[2] !== 1'b1) begin
      errors++; $display("FAIL single_word: got v=%b d=%h l=%b want 0100/a5a5/1",
                         bus.out_valid, ch_data(2), bus.out_last[2]);
    end
    vectors++;
    if (ch_cnt(2) !== 2'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_cnt: got cnt=%0d busy=%b want 1/0", ch_cnt(2), busy);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 4'b0000) begin
      errors++; $display("FAIL single_drain: got %b want 0000", bus.out_valid);
    end
  endtask

  task automatic test_packet_hold;
    bus.out_ready = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      drive(16'(i + 1), (i == 0) ? 2'd1 : 2'd3, (i == 3));
      tick();
      vectors++;
      if (bus.out_valid !== 4'b0010 || ch_data(1) !== 16'(i + 1) ||
          bus.out_last[1] !== (i == 3)) begin
        errors++; $display("FAIL pkt_word%0d: got v=%b d=%h l=%b want 0010/%h/%b", i,
                           bus.out_valid, ch_data(1), bus.out_last[1], 16'(i + 1), (i == 3));
      end
      vectors++;
      if (busy !== (i < 3) || cur_sel !== ((i < 3) ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL pkt_lock%0d: got busy=%b sel=%0d want %b/%0d", i, busy,
                           cur_sel, (i < 3), (i < 3) ? 1 : 0);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    vectors++;
    if (ch_cnt(1) !== 2'd1 || bus.out_valid !== 4'b0000) begin
      errors++; $display("FAIL pkt_end: got cnt=%0d v=%b want 1/0000", ch_cnt(1), bus.out_valid);
    end
  endtask

  task automatic test_backpressure;
    bus.out_ready = 4'b0000;
    drive(16'h1111, 2'd0, 1'b1);
    tick();
    drive(16'h2222, 2'd0, 1'b1);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall: got in_ready=%b want 0", bus.in_ready);
    end
    tick();
    vectors++;
    if (ch_data(0) !== 16'h1111 || bus.out_valid !== 4'b0001) begin
      errors++; $display("FAIL bp_hold: got d=%h v=%b want 1111/0001", ch_data(0), bus.out_valid);
    end
    bus.out_ready = 4'b0001;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (ch_data(0) !== 16'h2222 || bus.out_valid[0] !== 1'b1) begin
      errors++; $display("FAIL bp_second: got d=%h v=%b want 2222/1", ch_data(0),
                         bus.out_valid[0]);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 4'b0000 || ch_cnt(0) !== 2'd2) begin
      errors++; $display("FAIL bp_end: got v=%b cnt=%0d want 0000/2", bus.out_valid, ch_cnt(0));
    end
  endtask

  task automatic test_independent_drain;
    bus.out_ready = 4'b0000;
    drive(16'h1234, 2'd2, 1'b1);
    tick();
    drive(16'hC000, 2'd3, 1'b0);
    tick();
    drive(16'hC001, 2'd0, 1'b1);
    bus.out_ready = 4'b0100;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b1 || cur_sel !== 2'd3) begin
      errors++; $display("FAIL ind_stall: got rdy=%b busy=%b sel=%0d want 0/1/3", bus.in_ready,
                         busy, cur_sel);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 4'b1000 || ch_data(3) !== 16'hC000 || ch_data(2) !== 16'h1234) begin
      errors++; $display("FAIL ind_drain: got v=%b d3=%h d2=%h want 1000/c000/1234",
                         bus.out_valid, ch_data(3), ch_data(2));
    end
    bus.out_ready = 4'b1000;
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (ch_data(3) !== 16'hC001 || bus.out_last[3] !== 1'b1 || busy !== 1'b0 ||
        cur_sel !== 2'd0) begin
      errors++; $display("FAIL ind_last: got d=%h l=%b busy=%b sel=%0d want c001/1/0/0",
                         ch_data(3), bus.out_last[3], busy, cur_sel);
    end
    tick();
    vectors++;
    if (ch_cnt(2) !== 2'd2 || ch_cnt(3) !== 2'd1) begin
      errors++; $display("FAIL ind_cnt: got c2=%0d c3=%0d want 2/1", ch_cnt(2), ch_cnt(3));
    end
  endtask

  task automatic test_reset_mid_packet;
    bus.out_ready = 4'b0000;
    drive(16'hBEEF, 2'd1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_busy: got %b want 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || cur_sel !== 2'd0 || bus.out_valid !== 4'b0000 || pkt_cnt !== '0) begin
      errors++; $display("FAIL rst_mid: got busy=%b sel=%0d v=%b cnt=%h want 0", busy, cur_sel,
                         bus.out_valid, pkt_cnt);
    end
  endtask

  task automatic test_counter_wrap;
    do_reset();
    bus.out_ready = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      drive(16'(16'h0100 + i), 2'd0, 1'b1);
      tick();
      vectors++;
      if (ch_cnt(0) !== 2'((i + 1) % 4)) begin
        errors++; $display("FAIL cnt_wrap%0d: got %0d want %0d", i, ch_cnt(0), (i + 1) % 4);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random(input int cycles);
    int         cnt_m [4];
    logic [1:0] pk_sel;
    int         left;
    bit         first;
    logic [W-1:0] wd;
    logic       exp_rdy;
    logic [W:0] front;
    bit         drain;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cnt_m[k] = 0;
      exp_q[k].delete();
    end
    left  = 0;
    first = 1'b1;
    pk_sel = 2'd0;
    wd = 16'($urandom);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      drain = (c >= cycles - 3);
      if (left == 0) begin
        pk_sel = 2'($urandom_range(0, 3));
        left   = $urandom_range(1, 4);
        first  = 1'b1;
      end
      bus.in_data   = wd;
      bus.in_last   = (left == 1);
      bus.in_sel    = first ? pk_sel : 2'($urandom);
      bus.in_valid  = !drain && ($urandom_range(0, 3) != 0);
      bus.out_ready = drain ? 4'hF : 4'($urandom);
      #1;
      // A word can enter its channel when that channel's single slot is free or emptying.
      exp_rdy = (exp_q[pk_sel].size() == 0) || bus.out_ready[pk_sel];
      vectors++;
      if (bus.in_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.in_ready, exp_rdy);
      end
      vectors++;
      if (busy !== !first || cur_sel !== (first ? 2'd0 : pk_sel)) begin
        errors++; $display("FAIL rnd_lock c%0d: got busy=%b sel=%0d want %b/%0d", c, busy,
                           cur_sel, !first, first ? 2'd0 : pk_sel);
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (bus.out_valid[k] !== (exp_q[k].size() != 0)) begin
          errors++; $display("FAIL rnd_valid c%0d ch%0d: got %b want %b", c, k,
                             bus.out_valid[k], exp_q[k].size() != 0);
        end
        if (bus.out_valid[k] && bus.out_ready[k] && exp_q[k].size() != 0) begin
          front = exp_q[k].pop_front();
          vectors++;
          if ({bus.out_last[k], ch_data(k)} !== front) begin
            errors++; $display("FAIL rnd_data c%0d ch%0d: got %h want %h", c, k,
                               {bus.out_last[k], ch_data(k)}, front);
          end
        end
      end
      if (bus.in_valid && exp_rdy) begin
        exp_q[pk_sel].push_back({(left == 1), wd});
        if (left == 1) cnt_m[pk_sel]++;
        left--;
        first = 1'b0;
        wd = 16'($urandom);
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 4'b0000) begin
      errors++; $display("FAIL rnd_final_valid: got %b want 0000", bus.out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (ch_cnt(k) !== 2'(cnt_m[k] % 4)) begin
        errors++; $display("FAIL rnd_cnt ch%0d: got %0d want %0d", k, ch_cnt(k), cnt_m[k] % 4);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = 2'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 4'b0000;
    test_reset();
    test_single_word();
    test_packet_hold();
    test_backpressure();
    test_independent_drain();
    test_reset_mid_packet();
    test_counter_wrap();
    test_random(2000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
